micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Stage-counting control unit for the 8-bit bus CPU. It replaces the fixed five-stage controller with variable-length instructions, a flags register, conditional jumps, STA and LDI, and run/pause/single-step/halt control. It sits between the instruction register (opcode nibble), the ALU (carry/zero) and every bus driver and load enable in the datapath.

## Interface
- No parameters; widths and encodings are fixed by the shared package.
- CLK  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr  in  4  opcode, the upper nibble of the instruction register.
- alu_carry  in  1  ALU carry-out.
- alu_zero  in  1  ALU result == 0.
- run  in  1  level; 1 = free-run, 0 = pause at the next instruction boundary.
- step  in  1  one-cycle pulse; executes one instruction while paused.
- ctrl  out  16  control word. Bits: J0 CO1 CE2 OI3 BI4 SU5 SO6 AO7 AI8 II9 IO10 RO11 RI12 MI13 HLT14 FI15.
- stage  out  3  current T-state, 0–4.
- paused  out  1  1 in PAUSED.
- halted  out  1  1 in HALTED.
- carry_flag, zero_flag  out  1 each  flags register.

## Operation
- Modes: PAUSED, RUN, STEP, HALTED.
- `ctrl` is a combinational decode of (mode, stage, instr, flags). It is 0 in PAUSED and HALTED.
- Datapath registers sample `ctrl` at the rising edge that ends the stage.
- Common fetch stages:
  - T0 = MI|CO
  - T1 = RO|II|CE
- Opcodes:
  - NOP 0000: T2 = 0.
  - LDA 0001: T2 = MI|IO; T3 = RO|AI.
  - ADD 0010: T2 = MI|IO; T3 = RO|BI; T4 = SO|AI|FI.
  - SUB 0011: as ADD, with T4 = SO|SU|AI|FI.
  - STA 0100: T2 = MI|IO; T3 = AO|RI.
  - LDI 0101: T2 = IO|AI.
  - JMP 0110: T2 = IO|J.
  - JC 0111: T2 = IO|J if carry_flag, else 0.
  - JZ 1000: T2 = IO|J if zero_flag, else 0.
  - OUT 1110: T2 = AO|OI.
  - HLT 1111: T2 = HLT.
  - Undefined opcodes: treated as NOP.
- Instruction length:
  - 3 stages: NOP, LDI, JMP, JC, JZ, OUT, HLT.
  - 4 stages: LDA, STA.
  - 5 stages: ADD, SUB.
  - No dead stages: the last stage is followed directly by T0.
- Flags: on any edge where FI=1, carry_flag ← alu_carry and zero_flag ← alu_zero. They hold otherwise.
- Mode transitions, all taken at the end of an instruction's last stage unless stated:
  - RUN with run=0: go to PAUSED with stage=0. The current instruction always completes.
  - PAUSED at the next edge: run=1 goes to RUN; run=0 with step=1 goes to STEP. If run and step are both 1, run wins.
  - STEP: executes exactly one instruction, then returns to PAUSED.
  - HLT in RUN or STEP: after its T2, go to HALTED. HALTED is exited only by rst; run and step are ignored.
- step is ignored in RUN, STEP and HALTED.

## Timing
- Reset values: mode=PAUSED, stage=0, ctrl=0, flags=0, paused=1, halted=0.
- Reset is honoured in any mode or stage. An instruction in progress is abandoned.
- First cycle after leaving PAUSED shows T0. Latency from run rising to MI|CO is 1 cycle.
- stage increments by 1 each cycle in RUN/STEP and wraps to 0 after the last stage. It never exceeds 4.
- Flags are updated at the same edge that loads A with the ALU result. A JC/JZ issued by the next instruction sees the new values.
- instr is assumed stable from the end of T1 to the end of the instruction. The sequencer does not latch it.

## Structure
- Package cpu_pkg holds:
  - opcode localparams;
  - control-bit index localparams (bits 0–15);
  - the mode enum (PAUSED, RUN, STEP, HALTED);
  - stage width.
- Sub-module microcode_rom: purely combinational (stage, instr, carry_flag, zero_flag) → {ctrl_word, last_stage}.
- The top level holds the mode FSM, stage counter, flags register and output gating.

## Test plan
- rst, then run=1: cycle 1 ctrl=0x0000 with paused=1. Cycle 2: T0, ctrl=0x2002. Cycle 3: T1, ctrl=0x0A04.
- ADD with alu_carry=1, alu_zero=0: T2=0x2400, T3=0x0810, T4=0x8140. The next cycle shows stage=0, carry_flag=1, zero_flag=0.
- JC with carry_flag=0: T2=0x0000. With carry_flag=1: T2=0x0401. Either way the next stage is 0.
- HLT: T2=0x4000, then halted=1 and ctrl=0 for ≥10 cycles despite run=1 and step pulses. rst returns to paused=1, halted=0.
- LDA running, run dropped during T3: T3 ctrl=0x0900, then paused at stage 0. A later step pulse gives exactly 4 cycles (0x2002, 0x0A04, 0x2400, 0x0900) and then paused=1.
- rst at T3 of SUB with flags previously 1/1: the next cycle shows stage=0, paused=1, flags 0/0, ctrl=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, control-bit indices, mode enum and widths for the bus CPU
package cpu_pkg;

    localparam int STAGE_W = 3;
    localparam int CTRL_W  = 16;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_STA = 4'b0100;
    localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam int CTRL_J   = 0;
    localparam int CTRL_CO  = 1;
    localparam int CTRL_CE  = 2;
    localparam int CTRL_OI  = 3;
    localparam int CTRL_BI  = 4;
    localparam int CTRL_SU  = 5;
    localparam int CTRL_SO  = 6;
    localparam int CTRL_AO  = 7;
    localparam int CTRL_AI  = 8;
    localparam int CTRL_II  = 9;
    localparam int CTRL_IO  = 10;
    localparam int CTRL_RO  = 11;
    localparam int CTRL_RI  = 12;
    localparam int CTRL_MI  = 13;
    localparam int CTRL_HLT = 14;
    localparam int CTRL_FI  = 15;

    typedef enum logic [1:0] {
        MODE_PAUSED = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_STEP   = 2'd2,
        MODE_HALTED = 2'd3
    } mode_t;

    // One-hot control word with only bit idx set.
    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        logic [CTRL_W-1:0] one;
        one = {{(CTRL_W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational microcode: (stage, opcode, flags) to control word and last-stage marker
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [OP_W-1:0]    instr,
    input  logic               carry_flag,
    input  logic               zero_flag,
    output logic [CTRL_W-1:0]  ctrl_word,
    output logic               last_stage
);

    logic [STAGE_W-1:0] last_idx;

    always_comb begin
        case (instr)
            OP_LDA, OP_STA: last_idx = 3'd3;
            OP_ADD, OP_SUB: last_idx = 3'd4;
            default:        last_idx = 3'd2;
        endcase
        // >= rather than == so a stray stage value can never run past the end.
        last_stage = (stage >= last_idx);
    end

    always_comb begin
        ctrl_word = '0;
        case (stage)
            3'd0: ctrl_word = cbit(CTRL_MI) | cbit(CTRL_CO);
            3'd1: ctrl_word = cbit(CTRL_RO) | cbit(CTRL_II) | cbit(CTRL_CE);
            3'd2: begin
                case (instr)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl_word = cbit(CTRL_MI) | cbit(CTRL_IO);
                    OP_LDI: ctrl_word = cbit(CTRL_IO) | cbit(CTRL_AI);
                    OP_JMP: ctrl_word = cbit(CTRL_IO) | cbit(CTRL_J);
                    OP_JC:  ctrl_word = carry_flag ? (cbit(CTRL_IO) | cbit(CTRL_J)) : '0;
                    OP_JZ:  ctrl_word = zero_flag ? (cbit(CTRL_IO) | cbit(CTRL_J)) : '0;
                    OP_OUT: ctrl_word = cbit(CTRL_AO) | cbit(CTRL_OI);
                    OP_HLT: ctrl_word = cbit(CTRL_HLT);
                    default: ctrl_word = '0;
                endcase
            end
            3'd3: begin
                case (instr)
                    OP_LDA:         ctrl_word = cbit(CTRL_RO) | cbit(CTRL_AI);
                    OP_ADD, OP_SUB: ctrl_word = cbit(CTRL_RO) | cbit(CTRL_BI);
                    OP_STA:         ctrl_word = cbit(CTRL_AO) | cbit(CTRL_RI);
                    default:        ctrl_word = '0;
                endcase
            end
            3'd4: begin
                case (instr)
                    OP_ADD:  ctrl_word = cbit(CTRL_SO) | cbit(CTRL_AI) | cbit(CTRL_FI);
                    OP_SUB:  ctrl_word = cbit(CTRL_SO) | cbit(CTRL_SU) | cbit(CTRL_AI) | cbit(CTRL_FI);
                    default: ctrl_word = '0;
                endcase
            end
            default: ctrl_word = '0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - mode FSM, stage counter and flags register driving the datapath control word
module micro_sequencer
    import cpu_pkg::*;
(
    input  logic               CLK,
    input  logic               rst,
    input  logic [OP_W-1:0]    instr,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               run,
    input  logic               step,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [STAGE_W-1:0] stage,
    output logic               paused,
    output logic               halted,
    output logic               carry_flag,
    output logic               zero_flag
);

    mode_t              mode_q, mode_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic [CTRL_W-1:0]  rom_word;
    logic               rom_last;
    logic               active;

    microcode_rom u_rom (
        .stage      (stage_q),
        .instr      (instr),
        .carry_flag (carry_q),
        .zero_flag  (zero_q),
        .ctrl_word  (rom_word),
        .last_stage (rom_last)
    );

    assign active = (mode_q == MODE_RUN) || (mode_q == MODE_STEP);

    always_comb begin
        mode_d  = mode_q;
        stage_d = stage_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ctrl    = active ? rom_word : '0;

        case (mode_q)
            MODE_PAUSED: begin
                stage_d = '0;
                if (run)       mode_d = MODE_RUN;
                else if (step) mode_d = MODE_STEP;
            end
            MODE_RUN, MODE_STEP: begin
                if (rom_last) begin
                    stage_d = '0;
                    // Mode changes only at instruction boundaries; HLT beats pause.
                    if (rom_word[CTRL_HLT])                 mode_d = MODE_HALTED;
                    else if (mode_q == MODE_STEP || !run)   mode_d = MODE_PAUSED;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            default: stage_d = '0;
        endcase

        if (ctrl[CTRL_FI]) begin
            carry_d = alu_carry;
            zero_d  = alu_zero;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            mode_q  <= MODE_PAUSED;
            stage_q <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            stage_q <= stage_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign stage      = stage_q;
    assign paused     = (mode_q == MODE_PAUSED);
    assign halted     = (mode_q == MODE_HALTED);
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed and randomized self-checking bench for micro_sequencer
module tb_micro_sequencer;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  instr;
    logic        alu_carry, alu_zero;
    logic        run, step;
    logic [15:0] ctrl;
    logic [2:0]  stage;
    logic        paused, halted, carry_flag, zero_flag;

    int n_vec = 0;
    int n_err = 0;
    logic m_c, m_z;

    micro_sequencer dut (
        .CLK        (CLK),
        .rst        (rst),
        .instr      (instr),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .run        (run),
        .step       (step),
        .ctrl       (ctrl),
        .stage      (stage),
        .paused     (paused),
        .halted     (halted),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference tables written straight from the opcode listing.
    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd4: return 4;
            4'd2, 4'd3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input logic [3:0] op, input int t, input logic c, input logic z);
        if (t == 0) return 16'h2002;
        if (t == 1) return 16'h0A04;
        case (op)
            4'd1:  return (t == 2) ? 16'h2400 : 16'h0900;
            4'd2:  return (t == 2) ? 16'h2400 : (t == 3) ? 16'h0810 : 16'h8140;
            4'd3:  return (t == 2) ? 16'h2400 : (t == 3) ? 16'h0810 : 16'h8160;
            4'd4:  return (t == 2) ? 16'h2400 : 16'h1080;
            4'd5:  return 16'h0500;
            4'd6:  return 16'h0401;
            4'd7:  return c ? 16'h0401 : 16'h0000;
            4'd8:  return z ? 16'h0401 : 16'h0000;
            4'd14: return 16'h0088;
            4'd15: return 16'h4000;
            default: return 16'h0000;
        endcase
    endfunction

    // Entered just after an edge with the DUT running at T0; leaves at T0 of the next.
    task automatic run_model_instr(input logic [3:0] op);
        int n;
        logic [15:0] w;
        n = exp_len(op);
        instr = op;
        alu_carry = 1'($urandom);
        alu_zero = 1'($urandom);
        #1;
        for (int t = 0; t < n; t++) begin
            w = exp_word(op, t, m_c, m_z);
            chk("rnd_ctrl", ctrl, w);
            chk("rnd_stage", {13'd0, stage}, 16'(t));
            chk("rnd_paused", {15'd0, paused}, 16'd0);
            tick;
            if (w[15]) begin
                m_c = alu_carry;
                m_z = alu_zero;
            end
            chk("rnd_carry", {15'd0, carry_flag}, {15'd0, m_c});
            chk("rnd_zero", {15'd0, zero_flag}, {15'd0, m_z});
        end
        chk("rnd_wrap", {13'd0, stage}, 16'd0);
    endtask

    initial begin
        logic [15:0] seq4 [4];
        logic [3:0]  op;
        seq4[0] = 16'h2002; seq4[1] = 16'h0A04; seq4[2] = 16'h2400; seq4[3] = 16'h0900;

        rst = 1'b1; run = 1'b0; step = 1'b0; instr = 4'd7; alu_carry = 1'b0; alu_zero = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        chk("rst_ctrl", ctrl, 16'h0000);
        chk("rst_stage", {13'd0, stage}, 16'd0);
        chk("rst_paused", {15'd0, paused}, 16'd1);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_flags", {14'd0, carry_flag, zero_flag}, 16'd0);

        run = 1'b1;
        #1;
        chk("run_cyc1_ctrl", ctrl, 16'h0000);
        chk("run_cyc1_paused", {15'd0, paused}, 16'd1);
        tick;
        chk("run_t0", ctrl, 16'h2002);
        chk("run_t0_paused", {15'd0, paused}, 16'd0);
        tick;
        chk("run_t1", ctrl, 16'h0A04);
        tick;
        chk("jc_nc_t2", ctrl, 16'h0000);
        chk("jc_nc_stage", {13'd0, stage}, 16'd2);
        tick;
        chk("jc_nc_wrap", {13'd0, stage}, 16'd0);

        instr = 4'd2; alu_carry = 1'b1; alu_zero = 1'b0;
        #1;
        chk("add_t0", ctrl, 16'h2002);
        tick; chk("add_t1", ctrl, 16'h0A04);
        tick; chk("add_t2", ctrl, 16'h2400);
        tick; chk("add_t3", ctrl, 16'h0810);
        tick; chk("add_t4", ctrl, 16'h8140);
        chk("add_t4_stage", {13'd0, stage}, 16'd4);
        tick;
        chk("add_wrap", {13'd0, stage}, 16'd0);
        chk("add_carry", {15'd0, carry_flag}, 16'd1);
        chk("add_zero", {15'd0, zero_flag}, 16'd0);

        instr = 4'd7;
        #1;
        tick; tick;
        chk("jc_c_t2", ctrl, 16'h0401);
        tick;
        chk("jc_c_wrap", {13'd0, stage}, 16'd0);

        m_c = 1'b1; m_z = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 14));
            run_model_instr(op);
        end

        instr = 4'd1;
        #1;
        chk("lda_t0", ctrl, 16'h2002);
        tick; tick; tick;
        run = 1'b0;
        #1;
        chk("lda_t3", ctrl, 16'h0900);
        tick;
        chk("lda_paused", {15'd0, paused}, 16'd1);
        chk("lda_paused_stage", {13'd0, stage}, 16'd0);
        chk("lda_paused_ctrl", ctrl, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_paused", {15'd0, paused}, 16'd1);
            chk("hold_ctrl", ctrl, 16'h0000);
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            chk("step_lda_ctrl", ctrl, seq4[t]);
            chk("step_lda_stage", {13'd0, stage}, 16'(t));
            tick;
        end
        chk("step_lda_paused", {15'd0, paused}, 16'd1);
        chk("step_lda_ctrl_off", ctrl, 16'h0000);

        instr = 4'd2; alu_carry = 1'b1; alu_zero = 1'b1; step = 1'b1;
        tick;
        step = 1'b0;
        for (int t = 0; t < 5; t++) tick;
        chk("step_add_paused", {15'd0, paused}, 16'd1);
        chk("step_add_flags", {14'd0, carry_flag, zero_flag}, 16'd3);

        instr = 4'd3; alu_carry = 1'b0; alu_zero = 1'b0; run = 1'b1;
        tick; tick; tick; tick;
        chk("sub_t3", ctrl, 16'h0810);
        chk("sub_t3_stage", {13'd0, stage}, 16'd3);
        rst = 1'b1; run = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        chk("mid_rst_stage", {13'd0, stage}, 16'd0);
        chk("mid_rst_paused", {15'd0, paused}, 16'd1);
        chk("mid_rst_flags", {14'd0, carry_flag, zero_flag}, 16'd0);
        chk("mid_rst_ctrl", ctrl, 16'h0000);

        instr = 4'd15; run = 1'b1;
        tick; tick; tick;
        chk("hlt_t2", ctrl, 16'h4000);
        tick;
        for (int i = 0; i < 12; i++) begin
            step = i[0];
            #1;
            chk("halted", {15'd0, halted}, 16'd1);
            chk("halted_ctrl", ctrl, 16'h0000);
            chk("halted_paused", {15'd0, paused}, 16'd0);
            tick;
        end
        rst = 1'b1; step = 1'b0;
        tick;
        rst = 1'b0; run = 1'b0;
        #1;
        chk("unhalt_paused", {15'd0, paused}, 16'd1);
        chk("unhalt_halted", {15'd0, halted}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
